// File: rtl/de0_nano_system_i2c_scl_gen_if.sv
// ----------------------------------------------------------------------------
// de0_nano_system_i2c_scl_gen_if
//   Signal bundle between the I2C byte engine / PIO side and the SCL timing
//   generator.
//
//   sel         rate select (0 = ~100 kHz, 1 = 400 kHz)
//   enable      1 = keep generating SCL periods
//   scl_in      raw SCL pad level (asynchronous)
//   scl_oe      1 = pull SCL low, 0 = release
//   fall_tick   1-cycle strobe when scl_oe goes 0->1
//   rise_tick   1-cycle strobe on the first cycle the line is seen high
//   active_sel  rate in use for the current period
//   busy        generator is not idle
//
//   master : the side that drives sel/enable/scl_in and consumes the strobes
//   slave  : the SCL generator itself
// ----------------------------------------------------------------------------
interface de0_nano_system_i2c_scl_gen_if;
    logic sel;
    logic enable;
    logic scl_in;
    logic scl_oe;
    logic fall_tick;
    logic rise_tick;
    logic active_sel;
    logic busy;

    modport master (
        output sel,
        output enable,
        output scl_in,
        input  scl_oe,
        input  fall_tick,
        input  rise_tick,
        input  active_sel,
        input  busy
    );

    modport slave (
        input  sel,
        input  enable,
        input  scl_in,
        output scl_oe,
        output fall_tick,
        output rise_tick,
        output active_sel,
        output busy
    );
endinterface

// File: rtl/de0_nano_system_i2c_scl_gen.sv
// ----------------------------------------------------------------------------
// de0_nano_system_i2c_scl_gen
//   SCL timing generator for the on-board I2C master. Produces an open-drain
//   SCL drive (scl_oe) with fall/rise strobes for the byte engine. The rate
//   (standard or fast) is latched only when a new period starts, so a rate
//   change never produces a runt pulse. Slave clock stretching is honoured by
//   waiting for the synchronised line level before starting the HIGH phase.
//
// Ports
//   clk       system clock (50 MHz)
//   reset_n   asynchronous active-low reset
//   bus       de0_nano_system_i2c_scl_gen_if.slave:
//               sel, enable, scl_in (in) / scl_oe, fall_tick, rise_tick,
//               active_sel, busy (out, all registered)
//
// Timing (unstretched): LOW = half, WAIT_HIGH = 3 (synchroniser latency),
// HIGH = half, so one period is 2*half+3 clk cycles.
// ----------------------------------------------------------------------------
module de0_nano_system_i2c_scl_gen #(
    parameter int SLOW_HALF = 249,
    parameter int FAST_HALF = 61,
    parameter int CNT_W     = 9
) (
    input  logic                          clk,
    input  logic                          reset_n,
    de0_nano_system_i2c_scl_gen_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOW,
        ST_WAIT_HIGH,
        ST_HIGH
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               scl_oe_q, scl_oe_d;
    logic               fall_tick_q, fall_tick_d;
    logic               rise_tick_q, rise_tick_d;
    logic               active_sel_q, active_sel_d;
    logic               busy_q, busy_d;
    logic               scl_meta_q;
    logic               scl_sync_q;

    // Phase counter reload value: a phase lasts exactly 'half' cycles.
    function automatic logic [CNT_W-1:0] half_load(input logic fast);
        return fast ? CNT_W'(FAST_HALF - 1) : CNT_W'(SLOW_HALF - 1);
    endfunction

    // Two-flop synchroniser for the pad level; resets to the idle (high) level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
        end else begin
            scl_meta_q <= bus.scl_in;
            scl_sync_q <= scl_meta_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            scl_oe_q     <= 1'b0;
            fall_tick_q  <= 1'b0;
            rise_tick_q  <= 1'b0;
            active_sel_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            scl_oe_q     <= scl_oe_d;
            fall_tick_q  <= fall_tick_d;
            rise_tick_q  <= rise_tick_d;
            active_sel_q <= active_sel_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        scl_oe_d     = scl_oe_q;
        fall_tick_d  = 1'b0;
        rise_tick_d  = 1'b0;
        active_sel_d = active_sel_q;

        case (state_q)
            ST_IDLE: begin
                scl_oe_d = 1'b0;
                if (bus.enable) begin
                    state_d      = ST_LOW;
                    scl_oe_d     = 1'b1;
                    fall_tick_d  = 1'b1;
                    active_sel_d = bus.sel;
                    cnt_d        = half_load(bus.sel);
                end
            end

            // enable is deliberately ignored here: a LOW phase is never cut short.
            ST_LOW: begin
                if (cnt_q == '0) begin
                    state_d  = ST_WAIT_HIGH;
                    scl_oe_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            // Line released; stay here for as long as a slave stretches SCL.
            ST_WAIT_HIGH: begin
                if (scl_sync_q) begin
                    state_d     = ST_HIGH;
                    rise_tick_d = 1'b1;
                    cnt_d       = half_load(active_sel_q);
                end
            end

            // Period boundary: the only place besides IDLE where sel is sampled.
            ST_HIGH: begin
                if (cnt_q == '0) begin
                    if (bus.enable) begin
                        state_d      = ST_LOW;
                        scl_oe_d     = 1'b1;
                        fall_tick_d  = 1'b1;
                        active_sel_d = bus.sel;
                        cnt_d        = half_load(bus.sel);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                state_d  = ST_IDLE;
                scl_oe_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign bus.scl_oe     = scl_oe_q;
    assign bus.fall_tick  = fall_tick_q;
    assign bus.rise_tick  = rise_tick_q;
    assign bus.active_sel = active_sel_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_de0_nano_system_i2c_scl_gen.sv
// ----------------------------------------------------------------------------
// tb_de0_nano_system_i2c_scl_gen
//   Event scoreboard: each stimulus step pushes the strobes it should cause
//   (kind + absolute cycle, derived from the period arithmetic) and a monitor
//   pops and compares them as the DUT produces ticks. Level checks on scl_oe,
//   busy and active_sel are made at chosen cycles.
// ----------------------------------------------------------------------------
module tb_de0_nano_system_i2c_scl_gen;

    localparam int SLOW_HALF = 249;
    localparam int FAST_HALF = 61;
    localparam int CNT_W     = 9;
    localparam int FAST_P    = 2*FAST_HALF + 3;   // 125
    localparam int SLOW_P    = 2*SLOW_HALF + 3;   // 501
    localparam int RISE_OFS  = 3;                 // release -> rise_tick, unstretched

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic stretch_hold = 1'b0;

    de0_nano_system_i2c_scl_gen_if bus();

    // Open-drain line model: low when driven or when a slave stretches.
    assign bus.scl_in = ~bus.scl_oe & ~stretch_hold;

    de0_nano_system_i2c_scl_gen #(
        .SLOW_HALF (SLOW_HALF),
        .FAST_HALF (FAST_HALF),
        .CNT_W     (CNT_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        bit is_rise;
        int at;
    } evt_t;

    evt_t exp_q[$];
    evt_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input bit is_rise, input int at);
        evt_t e;
        e.is_rise = is_rise;
        e.at      = at;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Tick monitor: compares every produced strobe with the scoreboard head.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.fall_tick === 1'b1 || bus.rise_tick === 1'b1) begin
                if (bus.fall_tick === 1'b1 && bus.rise_tick === 1'b1)
                    chk("both_ticks", 1, 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_tick", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("tick_kind", {31'd0, bus.rise_tick}, {31'd0, mon_e.is_rise});
                    chk("tick_cycle", cyc, mon_e.at);
                end
            end else if (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
                mon_e = exp_q.pop_front();
                chk(mon_e.is_rise ? "missed_rise" : "missed_fall", 0, 1);
            end
        end
    end

    int f, r, f2, rise2, idle, k;

    initial begin
        bus.sel    = 1'b0;
        bus.enable = 1'b0;

        // T1: reset held while inputs toggle
        reset_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.sel    = i[0];
            bus.enable = i[1];
        end
        @(negedge clk);
        chk("rst_scl_oe", bus.scl_oe, 0);
        chk("rst_fall", bus.fall_tick, 0);
        chk("rst_rise", bus.rise_tick, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_asel", bus.active_sel, 0);
        bus.sel    = 1'b0;
        bus.enable = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("idle_busy", bus.busy, 0);

        // T2: fast rate, three periods, disable inside the last LOW
        f = cyc + 1;
        for (int p = 0; p < 3; p++) begin
            push(1'b0, f + p*FAST_P);
            push(1'b1, f + p*FAST_P + FAST_HALF + RISE_OFS);
        end
        bus.sel    = 1'b1;
        bus.enable = 1'b1;
        wait_cyc(f);
        chk("t2_oe_start", bus.scl_oe, 1);
        chk("t2_asel", bus.active_sel, 1);
        chk("t2_busy", bus.busy, 1);
        wait_cyc(f + FAST_HALF - 1);
        chk("t2_oe_low_end", bus.scl_oe, 1);
        wait_cyc(f + FAST_HALF);
        chk("t2_oe_release", bus.scl_oe, 0);
        wait_cyc(f + 2*FAST_P + 10);
        bus.enable = 1'b0;
        idle = f + 3*FAST_P;
        wait_cyc(idle - 1);
        chk("t2_busy_last_high", bus.busy, 1);
        wait_cyc(idle);
        chk("t2_busy_idle", bus.busy, 0);
        chk("t2_oe_idle", bus.scl_oe, 0);
        wait_cyc(idle + 20);

        // T3: slow period, switch to fast in the middle of LOW
        f = cyc + 1;
        push(1'b0, f);
        push(1'b1, f + SLOW_HALF + RISE_OFS);
        push(1'b0, f + SLOW_P);
        push(1'b1, f + SLOW_P + FAST_HALF + RISE_OFS);
        push(1'b0, f + SLOW_P + FAST_P);
        push(1'b1, f + SLOW_P + FAST_P + FAST_HALF + RISE_OFS);
        bus.sel    = 1'b0;
        bus.enable = 1'b1;
        wait_cyc(f);
        chk("t3_asel_slow", bus.active_sel, 0);
        wait_cyc(f + 100);
        bus.sel = 1'b1;
        wait_cyc(f + SLOW_P - 1);
        chk("t3_asel_hold", bus.active_sel, 0);
        wait_cyc(f + SLOW_P);
        chk("t3_asel_fast", bus.active_sel, 1);
        wait_cyc(f + SLOW_P + FAST_P + 10);
        bus.enable = 1'b0;
        idle = f + SLOW_P + 2*FAST_P;
        wait_cyc(idle);
        chk("t3_busy_idle", bus.busy, 0);
        wait_cyc(idle + 20);

        // T4: slave stretches 40 cycles; T5: disable 10 cycles into next LOW
        f     = cyc + 1;
        r     = f + FAST_HALF;
        f2    = r + 40 + 2 + FAST_HALF;
        rise2 = f2 + FAST_HALF + RISE_OFS;
        idle  = rise2 + FAST_HALF;
        push(1'b0, f);
        push(1'b1, r + 40 + 2);
        push(1'b0, f2);
        push(1'b1, rise2);
        bus.sel    = 1'b1;
        bus.enable = 1'b1;
        wait_cyc(r - 1);
        stretch_hold = 1'b1;
        wait_cyc(r);
        chk("t4_oe_release", bus.scl_oe, 0);
        wait_cyc(r + 39);
        stretch_hold = 1'b0;
        wait_cyc(f2 - 1);
        chk("t4_high_end", bus.scl_oe, 0);
        wait_cyc(f2);
        chk("t4_next_low", bus.scl_oe, 1);
        wait_cyc(f2 + 10);
        bus.enable = 1'b0;
        wait_cyc(idle - 1);
        chk("t5_busy_high", bus.busy, 1);
        wait_cyc(idle);
        chk("t5_busy_idle", bus.busy, 0);
        wait_cyc(idle + 2*FAST_P);
        chk("t5_no_more_ticks", exp_q.size(), 0);
        chk("t5_oe_idle", bus.scl_oe, 0);

        // T6: reset during LOW, restart with enable held high
        f = cyc + 1;
        push(1'b0, f);
        bus.sel    = 1'b1;
        bus.enable = 1'b1;
        wait_cyc(f + 20);
        chk("t6_oe_low", bus.scl_oe, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_async_oe", bus.scl_oe, 0);
        chk("t6_async_busy", bus.busy, 0);
        chk("t6_async_asel", bus.active_sel, 0);
        @(negedge clk);
        k = cyc;
        push(1'b0, k + 1);
        push(1'b1, k + 1 + FAST_HALF + RISE_OFS);
        reset_n = 1'b1;
        wait_cyc(k + 1);
        chk("t6_restart_oe", bus.scl_oe, 1);
        chk("t6_restart_asel", bus.active_sel, 1);
        wait_cyc(k + 10);
        bus.enable = 1'b0;
        idle = k + 1 + FAST_P;
        wait_cyc(idle);
        chk("t6_busy_idle", bus.busy, 0);
        wait_cyc(idle + 50);
        chk("end_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
